// File: rtl/ex_div.sv
// ex_div: iterative RV32M divider (DIV, DIVU, REM, REMU) for the EX stage.
// It uses restoring division and produces one quotient bit per cycle.
// Divide-by-zero and signed overflow are resolved in one cycle without
// entering CALC.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   div_start_i    request pulse, only accepted in IDLE
//   div_func3_i    100 DIV, 101 DIVU, 110 REM, 111 REMU
//   div_op1_i      dividend (rs1)
//   div_op2_i      divisor (rs2)
//   div_flush_i    abort any operation in progress
//   div_busy_o     stall request, high while iterating
//   div_ready_o    one-cycle result valid
//   div_result_o   quotient or remainder, held until the next result
module ex_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start_i,
    input  logic [2:0]       div_func3_i,
    input  logic [WIDTH-1:0] div_op1_i,
    input  logic [WIDTH-1:0] div_op2_i,
    input  logic             div_flush_i,
    output logic             div_busy_o,
    output logic             div_ready_o,
    output logic [WIDTH-1:0] div_result_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] AllOnes = '1;

    state_e           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder
    logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
    logic [WIDTH-1:0] result_q, result_d;
    logic             sel_rem_q, sel_rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;

    logic             is_signed, op1_neg, op2_neg, div_zero, overflow;
    logic [WIDTH-1:0] op1_mag, op2_mag;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] quo_next, rem_next, quo_fix, rem_fix;

    // func3[2] only marks the instruction as a divide; the decoder already filtered it.
    logic unused_func3;
    assign unused_func3 = div_func3_i[2];

    always_comb begin
        is_signed = ~div_func3_i[0];
        op1_neg   = is_signed & div_op1_i[WIDTH-1];
        op2_neg   = is_signed & div_op2_i[WIDTH-1];
        op1_mag   = op1_neg ? -div_op1_i : div_op1_i;
        op2_mag   = op2_neg ? -div_op2_i : div_op2_i;
        div_zero  = (div_op2_i == '0);
        overflow  = is_signed && (div_op1_i == MinNeg) && (div_op2_i == AllOnes);

        // Shift {rem, dividend} left by one and trial-subtract on WIDTH+1 bits.
        // The partial remainder is always below the divisor, so WIDTH bits hold it.
        diff     = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
        rem_next = diff[WIDTH] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : diff[WIDTH-1:0];
        quo_next = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
        quo_fix  = q_neg_q ? -quo_next : quo_next;
        rem_fix  = r_neg_q ? -rem_next : rem_next;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        sel_rem_d = sel_rem_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;

        if (div_flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (div_start_i) begin
                        sel_rem_d = div_func3_i[1];
                        if (div_zero) begin
                            result_d = div_func3_i[1] ? div_op1_i : AllOnes;
                            state_d  = StDone;
                        end else if (overflow) begin
                            result_d = div_func3_i[1] ? '0 : MinNeg;
                            state_d  = StDone;
                        end else begin
                            dvd_d   = op1_mag;
                            rem_d   = '0;
                            dvs_d   = op2_mag;
                            q_neg_d = op1_neg ^ op2_neg;
                            r_neg_d = op1_neg;
                            cnt_d   = '0;
                            state_d = StCalc;
                        end
                    end
                end
                StCalc: begin
                    dvd_d = quo_next;
                    rem_d = rem_next;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(WIDTH - 1)) begin
                        result_d = sel_rem_q ? rem_fix : quo_fix;
                        state_d  = StDone;
                    end
                end
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            sel_rem_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            sel_rem_q <= sel_rem_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
        end
    end

    assign div_busy_o   = (state_q == StCalc);
    assign div_ready_o  = (state_q == StDone);
    assign div_result_o = result_q;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: self-checking bench for ex_div. The expected results come from a
// 64-bit arithmetic model of the RV32M divide rules. The expected latency and
// busy counts come from the documented timing.
module tb_ex_div;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          div_start_i;
    logic [2:0]    div_func3_i;
    logic [W-1:0]  div_op1_i;
    logic [W-1:0]  div_op2_i;
    logic          div_flush_i;
    logic          div_busy_o;
    logic          div_ready_o;
    logic [W-1:0]  div_result_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_div #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_start_i  (div_start_i),
        .div_func3_i  (div_func3_i),
        .div_op1_i    (div_op1_i),
        .div_op2_i    (div_op2_i),
        .div_flush_i  (div_flush_i),
        .div_busy_o   (div_busy_o),
        .div_ready_o  (div_ready_o),
        .div_result_o (div_result_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // RV32M semantics via 64-bit arithmetic: truncating division, the remainder
    // takes the dividend's sign, x/0 = -1, x%0 = x, and overflow wraps naturally.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        sa = f3[0] ? longint'({32'b0, a}) : longint'($signed(a));
        sb = f3[0] ? longint'({32'b0, b}) : longint'($signed(b));
        if (sb == 0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return f3[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Advance one clock; outputs are sampled and inputs changed 1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one start and follow the operation through its ready pulse.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int lat;
        int busy_cnt;
        bit seen;
        div_func3_i = f3;
        div_op1_i   = a;
        div_op2_i   = b;
        div_start_i = 1'b1;
        step();
        div_start_i = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && lat <= 40) begin
            if (div_ready_o) begin
                seen = 1'b1;
            end else begin
                if (div_busy_o) busy_cnt++;
                step();
                lat++;
            end
        end
        check_val("latency", lat, is_special(f3, a, b) ? 1 : 33);
        check_val("busy_cycles", busy_cnt, is_special(f3, a, b) ? 0 : 32);
        check_val("busy_in_done", div_busy_o, 1'b0);
        check_val("result", div_result_o, exp);
        step();
        check_val("ready_single", div_ready_o, 1'b0);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t dir_vecs[16] = '{
        '{3'b101, 32'd100,        32'd7,          32'd14},
        '{3'b111, 32'd100,        32'd7,          32'd2},
        '{3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF},
        '{3'b100, -32'sd100,      32'd7,          32'hFFFF_FFF2},
        '{3'b110, -32'sd7,        32'd2,          32'hFFFF_FFFF},
        '{3'b100, 32'd7,          -32'sd2,        32'hFFFF_FFFD},
        '{3'b110, 32'd7,          -32'sd2,        32'd1},
        '{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF},
        '{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF},
        '{3'b110, 32'd5,          32'd0,          32'd5},
        '{3'b111, 32'h8000_0000,  32'd0,          32'h8000_0000},
        '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000},
        '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0},
        '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0},
        '{3'b111, 32'hDEAD_BEEF,  32'h0001_0000,  32'h0000_BEEF},
        '{3'b100, 32'h8000_0000,  32'd1,          32'h8000_0000}
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int pulses;
        int exp_pulses;
        logic [2:0]  f3;
        logic [31:0] a, b;

        rst         = 1'b1;
        div_start_i = 1'b0;
        div_flush_i = 1'b0;
        div_func3_i = 3'b100;
        div_op1_i   = '0;
        div_op2_i   = '0;
        step();
        step();
        check_val("rst_busy", div_busy_o, 1'b0);
        check_val("rst_ready", div_ready_o, 1'b0);
        check_val("rst_result", div_result_o, 32'd0);
        rst = 1'b0;
        step();

        // Directed vectors: check both the table values and the model.
        foreach (dir_vecs[i]) begin
            check_val("model_vs_table", ref_result(dir_vecs[i].f3, dir_vecs[i].a, dir_vecs[i].b),
                      dir_vecs[i].exp);
            run_op(dir_vecs[i].f3, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].exp);
        end

        // Flush at iteration 10 of a DIVU 1000/3.
        div_func3_i = 3'b101;
        div_op1_i   = 32'd1000;
        div_op2_i   = 32'd3;
        div_start_i = 1'b1;
        step();
        div_start_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_val("busy_before_flush", div_busy_o, 1'b1);
        div_flush_i = 1'b1;
        step();
        div_flush_i = 1'b0;
        check_val("flush_busy", div_busy_o, 1'b0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (div_ready_o) pulses++;
            step();
        end
        check_val("flush_no_ready", pulses, 0);
        run_op(3'b101, 32'd9, 32'd3, 32'd3);

        // Flush and start in the same cycle: the start is dropped.
        div_func3_i = 3'b101;
        div_op1_i   = 32'd50;
        div_op2_i   = 32'd0;
        div_start_i = 1'b1;
        div_flush_i = 1'b1;
        step();
        div_start_i = 1'b0;
        div_flush_i = 1'b0;
        check_val("flush_start_busy", div_busy_o, 1'b0);
        check_val("flush_start_ready", div_ready_o, 1'b0);

        // Reset in the middle of CALC.
        div_op2_i   = 32'd7;
        div_start_i = 1'b1;
        step();
        div_start_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        check_val("midrst_busy", div_busy_o, 1'b0);
        check_val("midrst_ready", div_ready_o, 1'b0);
        check_val("midrst_result", div_result_o, 32'd0);
        rst = 1'b0;
        step();

        // A start presented during DONE is ignored.
        run_op(3'b101, 32'd100, 32'd7, 32'd14);
        div_start_i = 1'b1;
        div_func3_i = 3'b101;
        div_op1_i   = 32'd40;
        div_op2_i   = 32'd0;
        // The ready pulse from the DONE cycle has already passed.
        // Re-enter DONE by using a special op, then hold start there.
        step();
        div_start_i = 1'b1;
        step();
        div_start_i = 1'b0;
        check_val("done_start_busy", div_busy_o, 1'b0);
        check_val("done_start_ready", div_ready_o, 1'b0);

        // Start held high: each operation takes 33 cycles, plus one DONE cycle
        // in which the start is ignored, so the accepts are 34 edges apart.
        div_func3_i = 3'b101;
        div_op1_i   = 32'd100;
        div_op2_i   = 32'd7;
        div_start_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (div_ready_o) begin
                pulses++;
                check_val("held_result", div_result_o, 32'd14);
            end
        end
        div_start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (div_ready_o) pulses++;
        end
        exp_pulses = (100 - 1) / 34 + 1;
        check_val("held_pulses", pulses, exp_pulses);

        // Randomized operations against the model.
        for (int n = 0; n < 60; n++) begin
            f3 = 3'b100 | 3'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 17));
                3: b = -32'($urandom_range(1, 17));
                default: b = $urandom;
            endcase
            run_op(f3, a, b, ref_result(f3, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_div.md
# ex_div

Iterative RV32M divider in the EX stage, executing DIV, DIVU, REM and REMU once the control unit has decoded them. It takes a start pulse, operands and func3 from the ID/EX register, and computes one quotient bit per cycle with restoring division. While it works it holds a stall request toward the pipeline. The result is presented for exactly one cycle, for capture into the EX/MEM register.

## Interface
- WIDTH, 32: operand and result width in bits.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- div_start_i  input  1  request pulse; accepted only in IDLE.
- div_func3_i  input  3  operation: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU. Captured at accept.
- div_op1_i  input  WIDTH  dividend (rs1); captured at accept.
- div_op2_i  input  WIDTH  divisor (rs2); captured at accept.
- div_flush_i  input  1  pipeline flush; aborts any operation in progress.
- div_busy_o  output  WIDTH'(1)  stall request; high in CALC only.
- div_ready_o  output  1  result valid; high in DONE only.
- div_result_o  output  WIDTH  quotient or remainder; meaningful only while div_ready_o is high.

## Operation
- **States:** IDLE, CALC, DONE; 2-bit state register.
  - 6-bit iteration counter.
  - Registers for dividend/quotient shift, partial remainder, divisor magnitude, func3, and result sign flags.
- **IDLE, start=1, divisor==0:** go to DONE with the special result.
  - Quotient = all ones (DIV and DIVU).
  - Remainder = op1 unchanged (REM and REMU).
- **IDLE, start=1, DIV/REM with op1==0x80000000 and op2==0xFFFFFFFF:** go to DONE with the special result.
  - Quotient = 0x80000000.
  - Remainder = 0.
- **IDLE, start=1, otherwise:** load operands and go to CALC with counter=0.
  - Signed ops (func3[0]==0) load magnitudes: |op1| and |op2|.
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
  - Unsigned ops load operands as-is, both signs 0.
- **CALC, each cycle:**
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor on a WIDTH+1-bit difference.
  - If non-negative: keep the difference and set quotient bit = 1; else quotient bit = 0.
  - Counter increments; after iteration 32 (counter==31 at the edge) go to DONE.
- **DONE:** div_ready_o=1.
  - div_result_o = quotient (func3[1]==0) or remainder (func3[1]==1).
  - Negate the result if the corresponding sign flag is set.
  - Next state is always IDLE.
- **Start outside IDLE:** ignored; no queueing.
- **Flush:** div_flush_i=1 forces IDLE at the next edge from any state.
  - No ready pulse is produced for the aborted operation.
  - Flush has priority over start in the same cycle; a start coinciding with flush is dropped.
- **Reset:** rst=1 sets state IDLE, counter 0, and all data registers 0.
  - div_busy_o=0, div_ready_o=0, div_result_o=0 in the cycle after reset.
  - Reset has priority over flush and start.

## Timing
- Start sampled at edge E0.
- **Normal ops:**
  - div_busy_o high from E0 to E32 (32 cycles).
  - div_ready_o high for one cycle, between E32 and E33.
  - Total latency: 33 cycles.
- **Special cases (divisor zero, overflow):**
  - div_busy_o never rises.
  - div_ready_o high between E0 and E1; latency 1.
- div_busy_o is low during DONE, so the pipeline advances and captures div_result_o at E33 (or E1).
- Back-to-back: a new start is accepted at E33 or later (IDLE). A start asserted during DONE is ignored; the pipeline must re-present it.
- div_ready_o is never high in two consecutive cycles.
- div_result_o is held stable while in DONE; value outside DONE is don't-care, but the implementation holds the last value.

## Test plan
- **Unsigned divide and remainder:**
  - DIVU 100/7 -> busy for 32 cycles; ready at cycle 33 with result 14.
  - REMU 100/7 -> result 2.
  - DIVU 0xFFFFFFFF/1 -> result 0xFFFFFFFF.
- **Signed combinations:**
  - DIV -100/7 -> 0xFFFFFFF2 (-14).
  - REM -7/2 -> 0xFFFFFFFF (-1).
  - DIV 7/-2 -> 0xFFFFFFFD (-3).
  - REM 7/-2 -> 1.
- **Divide by zero:**
  - DIV 5/0 and DIVU 5/0 -> ready after 1 cycle, busy never high, result 0xFFFFFFFF.
  - REM 5/0 -> result 5.
  - REMU 0x80000000/0 -> result 0x80000000.
- **Signed overflow:**
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after 1 cycle.
  - REM with the same operands -> 0.
  - DIVU with the same operands -> 0 after 33 cycles.
- **Flush and restart:**
  - DIVU 1000/3 started, flush at CALC iteration 10 -> busy drops next cycle; no ready pulse within 40 cycles.
  - Then DIVU 9/3 -> 3 at cycle 33.
  - Flush and start in the same cycle -> no operation starts.
- **Reset and ignored start:**
  - rst asserted mid-CALC -> busy=0, ready=0, result=0 next cycle.
  - Start held high throughout an operation -> exactly one ready pulse per accepted start.
  - A start during DONE is not accepted.
